// File: rtl/plank_tlm_pkg.sv
// Shared constants and helpers for the plank telemetry framer.
package plank_tlm_pkg;

  localparam logic [3:0] TYPE_FDBK = 4'h1;
  localparam logic [3:0] TYPE_ADC  = 4'h2;
  localparam logic [3:0] TYPE_TEMP = 4'h3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_CHAIN = 2'd3;

  function automatic logic [7:0] tlm_header(input logic [3:0] ident, input logic [3:0] typ);
    return {ident, typ};
  endfunction

  function automatic logic [7:0] tlm_csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/plank_tlm_framer_slot.sv
// One source slot: holding register, pending flag and overrun pulse.
module plank_tlm_slot #(
  parameter int BYTES = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [BYTES*8-1:0] data_i,
  input  logic               valid_i,
  input  logic               load_i,
  output logic [BYTES*8-1:0] data_o,
  output logic               pending_o,
  output logic               overrun_o
);

  logic [BYTES*8-1:0] hold_q;
  logic               pend_q;
  logic               ovr_q;

  // A strobe coinciding with a load is fresh data for the next frame, not an overrun.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= valid_i & pend_q & ~load_i;
      if (valid_i) begin
        hold_q <= data_i;
        pend_q <= 1'b1;
      end else if (load_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign data_o    = hold_q;
  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/plank_tlm_framer.sv
// Telemetry framer: arbitrates three source slots and emits
// {header, LSB-first payload, XOR checksum} one byte per UART completion.
//   state | meaning
//   IDLE  | nothing in flight; load highest-priority pending slot
//   ISSUE | present current byte, pulse dv, fold into checksum
//   WAIT  | wait for UART done, then next byte or frame end
//   CHAIN | after ADC frame, wait for TEMP up to CHAIN_TIMEOUT cycles
module plank_tlm_framer
  import plank_tlm_pkg::*;
#(
  parameter logic [3:0] IDENT         = 4'h2,
  parameter int         FDBK_BYTES    = 3,
  parameter int         ADC_BYTES     = 11,
  parameter int         TEMP_BYTES    = 3,
  parameter int         CHAIN_TIMEOUT = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [FDBK_BYTES*8-1:0] i_fdbk_data,
  input  logic                    i_fdbk_valid,
  input  logic [ADC_BYTES*8-1:0]  i_adc_data,
  input  logic                    i_adc_valid,
  input  logic [TEMP_BYTES*8-1:0] i_temp_data,
  input  logic                    i_temp_valid,
  input  logic                    i_chain_temp,
  output logic [7:0]              o_tx_byte,
  output logic                    o_tx_dv,
  input  logic                    i_tx_done,
  output logic                    o_busy,
  output logic [2:0]              o_overrun
);

  localparam int MAXB_FA = (FDBK_BYTES > ADC_BYTES) ? FDBK_BYTES : ADC_BYTES;
  localparam int MAXB    = (MAXB_FA > TEMP_BYTES) ? MAXB_FA : TEMP_BYTES;
  localparam int MAXW    = MAXB * 8;
  localparam int IDXW    = $clog2(MAXB + 2);
  localparam int CNTW    = $clog2(CHAIN_TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CHAIN_TIMEOUT - 1);

  logic [FDBK_BYTES*8-1:0] fdbk_hold;
  logic [ADC_BYTES*8-1:0]  adc_hold;
  logic [TEMP_BYTES*8-1:0] temp_hold;
  logic pend_f, pend_a, pend_t;
  logic ovr_f, ovr_a, ovr_t;
  logic ld_f, ld_a, ld_t;

  plank_tlm_slot #(.BYTES(FDBK_BYTES)) u_slot_fdbk (
    .clk_i(i_clk), .rst_ni(i_rst_n), .data_i(i_fdbk_data), .valid_i(i_fdbk_valid),
    .load_i(ld_f), .data_o(fdbk_hold), .pending_o(pend_f), .overrun_o(ovr_f));

  plank_tlm_slot #(.BYTES(ADC_BYTES)) u_slot_adc (
    .clk_i(i_clk), .rst_ni(i_rst_n), .data_i(i_adc_data), .valid_i(i_adc_valid),
    .load_i(ld_a), .data_o(adc_hold), .pending_o(pend_a), .overrun_o(ovr_a));

  plank_tlm_slot #(.BYTES(TEMP_BYTES)) u_slot_temp (
    .clk_i(i_clk), .rst_ni(i_rst_n), .data_i(i_temp_data), .valid_i(i_temp_valid),
    .load_i(ld_t), .data_o(temp_hold), .pending_o(pend_t), .overrun_o(ovr_t));

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d, len_q, len_d, last_idx;
  logic [3:0]      typ_q, typ_d;
  logic [MAXW-1:0] shift_q, shift_d;
  logic [7:0]      csum_q, csum_d, byte_q, byte_d, cur_byte;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            dv_q, dv_d;

  assign last_idx = len_q - IDXW'(1);

  always_comb begin
    if (idx_q == '0)            cur_byte = tlm_header(IDENT, typ_q);
    else if (idx_q == last_idx) cur_byte = csum_q;
    else                        cur_byte = shift_q[7:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    typ_d   = typ_q;
    shift_d = shift_q;
    csum_d  = csum_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    dv_d    = 1'b0;
    ld_f    = 1'b0;
    ld_a    = 1'b0;
    ld_t    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_f)      ld_f = 1'b1;
        else if (pend_a) ld_a = 1'b1;
        else if (pend_t) ld_t = 1'b1;
      end
      ST_ISSUE: begin
        byte_d  = cur_byte;
        dv_d    = 1'b1;
        csum_d  = tlm_csum_fold(csum_q, cur_byte);
        if (idx_q != '0 && idx_q != last_idx) shift_d = shift_q >> 8;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == last_idx) begin
            cnt_d   = '0;
            state_d = (typ_q == TYPE_ADC && i_chain_temp) ? ST_CHAIN : ST_IDLE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_CHAIN: begin
        // Only TEMP may follow an ADC frame here; other sources keep waiting.
        if (pend_t)                ld_t    = 1'b1;
        else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
        else                        cnt_d   = cnt_q + CNTW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (ld_f | ld_a | ld_t) begin
      idx_d   = '0;
      csum_d  = '0;
      state_d = ST_ISSUE;
      if (ld_f) begin
        typ_d   = TYPE_FDBK;
        len_d   = IDXW'(FDBK_BYTES + 2);
        shift_d = MAXW'(fdbk_hold);
      end else if (ld_a) begin
        typ_d   = TYPE_ADC;
        len_d   = IDXW'(ADC_BYTES + 2);
        shift_d = MAXW'(adc_hold);
      end else begin
        typ_d   = TYPE_TEMP;
        len_d   = IDXW'(TEMP_BYTES + 2);
        shift_d = MAXW'(temp_hold);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      typ_q   <= '0;
      shift_q <= '0;
      csum_q  <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      typ_q   <= typ_d;
      shift_q <= shift_d;
      csum_q  <= csum_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
    end
  end

  assign o_tx_byte = byte_q;
  assign o_tx_dv   = dv_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_overrun = {ovr_t, ovr_a, ovr_f};

endmodule

// File: tb/tb_plank_tlm_framer.sv
// Directed bench for plank_tlm_framer with a delayed-done UART model.
module tb_plank_tlm_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] fdbk_d = '0;
  logic        fdbk_v = 1'b0;
  logic [87:0] adc_d = '0;
  logic        adc_v = 1'b0;
  logic [23:0] temp_d = '0;
  logic        temp_v = 1'b0;
  logic        chain = 1'b0;
  logic        tx_done_m = 1'b0;
  logic        inj_done = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_dv, busy;
  logic [2:0]  ovr;

  always #5 clk = ~clk;

  plank_tlm_framer #(
    .IDENT(4'h2), .FDBK_BYTES(3), .ADC_BYTES(11), .TEMP_BYTES(3), .CHAIN_TIMEOUT(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fdbk_data(fdbk_d), .i_fdbk_valid(fdbk_v),
    .i_adc_data(adc_d), .i_adc_valid(adc_v),
    .i_temp_data(temp_d), .i_temp_valid(temp_v),
    .i_chain_temp(chain),
    .o_tx_byte(tx_byte), .o_tx_dv(tx_dv), .i_tx_done(tx_done_m | inj_done),
    .o_busy(busy), .o_overrun(ovr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap_q[$];
  int dvc_q[$];
  int done_q[$];
  int resp_delay = 3;
  int resp_cnt = 0;
  int b2b_n = 0, rst_dv_n = 0, ovr_n = 0;
  logic [2:0] ovr_last = '0;
  logic prev_dv = 1'b0;

  // UART model and output monitor, both sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      tx_done_m = 1'b0;
      if (tx_dv) begin
        cap_q.push_back(tx_byte);
        dvc_q.push_back(cyc);
        if (prev_dv) b2b_n++;
        if (!rst_n) rst_dv_n++;
        resp_cnt = resp_delay;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          tx_done_m = 1'b1;
          done_q.push_back(cyc);
        end
      end
      prev_dv = tx_dv;
      if (ovr != 3'b000) begin
        ovr_n++;
        ovr_last = ovr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int checks = 0, errors = 0, rd = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input int src, input logic [87:0] d);
    case (src)
      0: begin fdbk_d = d[23:0]; fdbk_v = 1'b1; end
      1: begin adc_d = d; adc_v = 1'b1; end
      default: begin temp_d = d[23:0]; temp_v = 1'b1; end
    endcase
    @(negedge clk);
    fdbk_v = 1'b0;
    adc_v = 1'b0;
    temp_v = 1'b0;
  endtask

  task automatic wait_quiet(input string name, input int limit);
    int idle_run;
    idle_run = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) idle_run++;
      else idle_run = 0;
      if (idle_run >= 4) return;
    end
    checks++;
    errors++;
    $display("FAIL %s timeout actual=busy expected=idle", name);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] hdr, input logic [87:0] data,
                             input int n, input logic [7:0] csum);
    if (cap_q.size() < rd + n + 2) begin
      chk({tag, "_len"}, cap_q.size() - rd, n + 2);
      rd = cap_q.size();
      return;
    end
    chk({tag, "_hdr"}, int'(cap_q[rd]), int'(hdr));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), int'(cap_q[rd + 1 + i]), int'(data[8*i +: 8]));
    chk({tag, "_csum"}, int'(cap_q[rd + n + 1]), int'(csum));
    rd += n + 2;
  endtask

  typedef struct {
    int          src;
    logic [87:0] data;
    int          n;
    logic [7:0]  hdr;
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs[5];
  localparam logic [87:0] ADC_SEQ = 88'h0A_09_08_07_06_05_04_03_02_01_00;

  initial begin
    int db, d, ovr0, base;
    vecs[0] = '{0, 88'h0155EE, 3, 8'h21, 8'h9B};
    vecs[1] = '{2, 88'h2020DD, 3, 8'h23, 8'hFE};
    vecs[2] = '{1, ADC_SEQ,    11, 8'h22, 8'h29};
    vecs[3] = '{0, 88'hFFFFFF, 3, 8'h21, 8'hDE};
    vecs[4] = '{2, 88'h000000, 3, 8'h23, 8'h23};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_dv", int'(tx_dv), 0);
    chk("rst_byte", int'(tx_byte), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(ovr), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single feedback frame, slow UART, latency and spacing
    resp_delay = 20;
    rd = cap_q.size();
    db = done_q.size();
    strobe(0, 88'h0155EE);
    chk("lat_k", int'(tx_dv), 0);
    @(negedge clk);
    chk("lat_k1", int'(tx_dv), 0);
    @(negedge clk);
    chk("lat_k2", int'(tx_dv), 1);
    chk("lat_hdr", int'(tx_byte), 8'h21);
    wait_quiet("single", 2000);
    chk("single_count", cap_q.size() - rd, 5);
    if (dvc_q.size() >= rd + 5 && done_q.size() >= db + 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("spacing_%0d", i), dvc_q[rd + 1 + i] - done_q[db + i], 2);
    else
      chk("spacing_avail", dvc_q.size() - rd, 5);
    check_frame("single", 8'h21, 88'h0155EE, 3, 8'h9B);
    resp_delay = 3;

    // table of individual frames
    for (int v = 0; v < 5; v++) begin
      rd = cap_q.size();
      strobe(vecs[v].src, vecs[v].data);
      wait_quiet($sformatf("vec%0d", v), 2000);
      chk($sformatf("vec%0d_count", v), cap_q.size() - rd, vecs[v].n + 2);
      check_frame($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].data, vecs[v].n, vecs[v].csum);
    end

    // simultaneous strobes: FDBK, ADC, TEMP order, no overrun
    rd = cap_q.size();
    ovr0 = ovr_n;
    fdbk_d = 24'h0155EE; adc_d = ADC_SEQ; temp_d = 24'h2020DD;
    fdbk_v = 1'b1; adc_v = 1'b1; temp_v = 1'b1;
    @(negedge clk);
    fdbk_v = 1'b0; adc_v = 1'b0; temp_v = 1'b0;
    wait_quiet("simul", 3000);
    check_frame("simul_f", 8'h21, 88'h0155EE, 3, 8'h9B);
    check_frame("simul_a", 8'h22, ADC_SEQ, 11, 8'h29);
    check_frame("simul_t", 8'h23, 88'h2020DD, 3, 8'hFE);
    chk("simul_ovr", ovr_n - ovr0, 0);

    // chain mode: TEMP jumps ahead of FDBK after ADC
    chain = 1'b1;
    rd = cap_q.size();
    strobe(1, ADC_SEQ);
    repeat (10) @(negedge clk);
    strobe(0, 88'hFFFFFF);
    repeat (5) @(negedge clk);
    strobe(2, 88'h000000);
    wait_quiet("chain", 3000);
    check_frame("chain_a", 8'h22, ADC_SEQ, 11, 8'h29);
    check_frame("chain_t", 8'h23, 88'h000000, 3, 8'h23);
    check_frame("chain_f", 8'h21, 88'hFFFFFF, 3, 8'hDE);

    // chain timeout: busy holds 16 cycles after ADC checksum done
    rd = cap_q.size();
    db = done_q.size();
    strobe(1, ADC_SEQ);
    repeat (10) @(negedge clk);
    strobe(0, 88'h0155EE);
    begin
      int lim;
      lim = 0;
      while (busy && lim < 2000) begin
        @(negedge clk);
        lim++;
      end
    end
    if (done_q.size() >= db + 13) begin
      d = done_q[db + 12];
      chk("to_busy_low", cyc - d, 17);
      wait_quiet("timeout", 2000);
      if (dvc_q.size() > rd + 13) chk("to_fdbk_dv", dvc_q[rd + 13] - d, 19);
      else chk("to_fdbk_avail", dvc_q.size() - rd, 18);
    end else begin
      chk("to_adc_dones", done_q.size() - db, 13);
      wait_quiet("timeout", 2000);
    end
    check_frame("to_a", 8'h22, ADC_SEQ, 11, 8'h29);
    check_frame("to_f", 8'h21, 88'h0155EE, 3, 8'h9B);
    chain = 1'b0;

    // overrun: ADC A then B during an FDBK frame
    rd = cap_q.size();
    ovr0 = ovr_n;
    strobe(0, 88'h0155EE);
    repeat (4) @(negedge clk);
    strobe(1, ADC_SEQ);
    repeat (2) @(negedge clk);
    strobe(1, 88'h5A);
    wait_quiet("ovr", 3000);
    chk("ovr_pulses", ovr_n - ovr0, 1);
    chk("ovr_bits", int'(ovr_last), 3'b010);
    check_frame("ovr_f", 8'h21, 88'h0155EE, 3, 8'h9B);
    check_frame("ovr_a", 8'h22, 88'h5A, 11, 8'h78);
    chk("ovr_only2", cap_q.size() - rd, 0);

    // reset mid-frame after the third ADC payload byte
    rd = cap_q.size();
    strobe(1, ADC_SEQ);
    for (int i = 0; i < 500 && cap_q.size() < rd + 4; i++) @(negedge clk);
    chk("rst_reach", cap_q.size() - rd, 4);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_resume", cap_q.size() - rd, 4);
    chk("rst_no_dv", rst_dv_n, 0);
    rd = cap_q.size();
    strobe(0, 88'hA53C0F);
    wait_quiet("rst_after", 2000);
    chk("rst_after_count", cap_q.size() - rd, 5);
    check_frame("rst_after", 8'h21, 88'hA53C0F, 3, 8'hB7);

    // done glitches in IDLE, then load coinciding with a re-strobe
    base = cap_q.size();
    for (int i = 0; i < 4; i++) begin
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      @(negedge clk);
    end
    chk("glitch_no_dv", cap_q.size() - base, 0);
    chk("glitch_busy", int'(busy), 0);
    rd = cap_q.size();
    ovr0 = ovr_n;
    fdbk_d = 24'h123456;
    fdbk_v = 1'b1;
    @(negedge clk);
    fdbk_d = 24'h0000AB;
    @(negedge clk);
    fdbk_v = 1'b0;
    wait_quiet("restrobe", 2000);
    check_frame("restrobe_x", 8'h21, 88'h123456, 3, 8'h51);
    check_frame("restrobe_y", 8'h21, 88'h0000AB, 3, 8'h8A);
    chk("restrobe_ovr", ovr_n - ovr0, 0);

    chk("no_b2b_dv", b2b_n, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
